// File: rtl/msg_box_anim.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | msg_box_anim : animated bordered message box overlay for the VGA path.    |
// | Optional: MSG_BLINK_EN blinks the border while the box is fully open.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module msg_box_anim #(
  parameter int          X0     = 200,
  parameter int          Y0     = 140,
  parameter int          W      = 240,
  parameter int          H      = 200,
  parameter int          BORDER = 4,
  parameter int          STEP   = 10,
  parameter int          CW     = 3,
  parameter logic [CW-1:0] FILL = 3'b011,
  parameter logic [CW-1:0] EDGE = 3'b111
`ifdef MSG_BLINK_EN
  ,
  parameter int          BLINK  = 30
`endif
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [9:0]    x,
  input  logic [9:0]    y,
  input  logic          frame_tick,
  input  logic          show,
  output logic [CW-1:0] rgb,
  output logic          visible,
  output logic          opened
);

  localparam int HH = H / 2;
  localparam int HW = $clog2(HH + 1);
  localparam int YC = Y0 + HH;

  localparam logic [HW-1:0] c_hh   = HW'(HH);
  localparam logic [HW-1:0] c_step = HW'((STEP > HH) ? HH : STEP);
  localparam logic [31:0]   c_xl   = 32'(X0);
  localparam logic [31:0]   c_xr   = 32'(X0 + W);
  localparam logic [31:0]   c_bd   = 32'(BORDER);
  localparam logic [31:0]   c_yc   = 32'(YC);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } state_t;

  state_t        r_state;
  logic [HW-1:0] r_h;
  logic          r_visible;
  logic          r_opened;
  logic [CW-1:0] r_rgb;

  // Saturating step arithmetic, one bit wider than h so the sum cannot wrap.
  logic [HW:0]   w_sum;
  logic [HW-1:0] w_up;
  logic [HW-1:0] w_dn;

  assign w_sum = {1'b0, r_h} + {1'b0, c_step};
  assign w_up  = (w_sum >= {1'b0, c_hh}) ? c_hh : w_sum[HW-1:0];
  assign w_dn  = (r_h > c_step) ? (r_h - c_step) : '0;

  // Growing from CLOSED starts from h=0, and leaving OPEN starts from h=H/2,
  // so every state reduces to the same grow/shrink rule on the current h.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_CLOSED;
      r_h       <= '0;
      r_visible <= 1'b0;
      r_opened  <= 1'b0;
    end else if (frame_tick) begin
      case (r_state)
        ST_CLOSED, ST_OPENING, ST_OPEN, ST_CLOSING: begin
          if (show) begin
            r_h       <= w_up;
            r_state   <= (w_up == c_hh) ? ST_OPEN : ST_OPENING;
            r_visible <= (w_up != '0);
            r_opened  <= (w_up == c_hh);
          end else begin
            r_h       <= w_dn;
            r_state   <= (w_dn == '0) ? ST_CLOSED : ST_CLOSING;
            r_visible <= (w_dn != '0);
            r_opened  <= 1'b0;
          end
        end
        default: begin
          r_state   <= ST_CLOSED;
          r_h       <= '0;
          r_visible <= 1'b0;
          r_opened  <= 1'b0;
        end
      endcase
    end
  end

  logic [CW-1:0] w_edge_col;

`ifdef MSG_BLINK_EN
  logic [7:0] r_blink;

  // Runs only while the box stays open; any exit from OPEN restarts it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_blink <= '0;
    end else if (frame_tick) begin
      if (r_state == ST_OPEN && show)
        r_blink <= (r_blink == 8'(BLINK - 1)) ? '0 : r_blink + 8'd1;
      else
        r_blink <= '0;
    end
  end

  assign w_edge_col = (r_blink < 8'(BLINK / 2)) ? EDGE : FILL;
`else
  assign w_edge_col = EDGE;
`endif

  logic [31:0] w_x;
  logic [31:0] w_y;
  logic [31:0] w_top;
  logic [31:0] w_bot;
  logic        w_in_box;
  logic        w_border;

  assign w_x   = {22'd0, x};
  assign w_y   = {22'd0, y};
  assign w_top = c_yc - 32'(r_h);
  assign w_bot = c_yc + 32'(r_h);

  assign w_in_box = (w_x >= c_xl) && (w_x < c_xr) &&
                    (w_y >= w_top) && (w_y < w_bot);
  assign w_border = w_in_box &&
                    ((w_x < c_xl + c_bd) || (w_x >= c_xr - c_bd) ||
                     (w_y < w_top + c_bd) || (w_y + c_bd >= w_bot));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_rgb <= '0;
    else if (w_border)
      r_rgb <= w_edge_col;
    else if (w_in_box)
      r_rgb <= FILL;
    else
      r_rgb <= '0;
  end

  assign rgb     = r_rgb;
  assign visible = r_visible;
  assign opened  = r_opened;

endmodule
`default_nettype wire

// File: tb/tb_msg_box_anim.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_msg_box_anim : directed self-checking bench for msg_box_anim.          |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_msg_box_anim;

  logic       clk;
  logic       rst_n;
  logic [9:0] x;
  logic [9:0] y;
  logic       frame_tick;
  logic       show;
  logic [2:0] rgb;
  logic       visible;
  logic       opened;

  int r_checks = 0;
  int r_errors = 0;

  localparam int c_closed  = 0;
  localparam int c_opening = 1;
  localparam int c_open    = 2;
  localparam int c_closing = 3;

  msg_box_anim dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .x          (x),
    .y          (y),
    .frame_tick (frame_tick),
    .show       (show),
    .rgb        (rgb),
    .visible    (visible),
    .opened     (opened)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    r_checks++;
    if (got !== exp) begin
      r_errors++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic tick(input logic s);
    show       = s;
    frame_tick = 1'b1;
    @(posedge clk);
    #1;
    frame_tick = 1'b0;
  endtask

  task automatic pix(input string tag, input int px, input int py, input int exp);
    x = 10'(px);
    y = 10'(py);
    @(posedge clk);
    #1;
    chk(tag, 32'(rgb), 32'(exp));
    x = '0;
    y = '0;
  endtask

  task automatic chk_st(input string tag, input int h, input int st);
    chk({tag, "_h"}, 32'(dut.r_h), 32'(h));
    chk({tag, "_st"}, 32'(dut.r_state), 32'(st));
  endtask

  initial begin
    rst_n      = 1'b0;
    x          = '0;
    y          = '0;
    frame_tick = 1'b0;
    show       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(rgb), 0);
    chk("rst_vis", 32'(visible), 0);
    chk("rst_opn", 32'(opened), 0);
    chk_st("rst", 0, c_closed);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Opening: 10 ticks, h grows by 10 each frame
    for (int i = 1; i <= 10; i++) begin
      tick(1'b1);
      chk($sformatf("open%0d_h", i), 32'(dut.r_h), 32'(10 * i));
      chk($sformatf("open%0d_opn", i), 32'(opened), (i == 10) ? 32'd1 : 32'd0);
      chk($sformatf("open%0d_vis", i), 32'(visible), 32'd1);
    end
    chk("open_st", 32'(dut.r_state), c_open);

    // Full box spans x 200..439, y 140..339
    pix("fill_ctr",   320, 240, 3);
    pix("edge_left",  202, 240, 7);
    pix("corner_tl",  200, 140, 7);
    pix("out_left",   199, 240, 0);
    pix("edge_right", 439, 240, 7);
    pix("out_right",  440, 240, 0);
    pix("edge_bot",   320, 339, 7);
    pix("out_bot",    320, 340, 0);
    pix("fill_top",   320, 144, 3);
    pix("out_top",    320, 139, 0);

    // show changes between ticks must not move anything
    show = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_st("hold", 100, c_open);
    chk("hold_opn", 32'(opened), 1);

    // Closing
    tick(1'b0);
    chk_st("close1", 90, c_closing);
    chk("close1_opn", 32'(opened), 0);
    chk("close1_vis", 32'(visible), 1);
    repeat (9) tick(1'b0);
    chk_st("closed", 0, c_closed);
    chk("closed_vis", 32'(visible), 0);
    pix("closed_ctr", 320, 240, 0);
    pix("closed_yc",  200, 240, 0);

    // Toggle pattern 1,1,0,1
    tick(1'b1); chk_st("tog1", 10, c_opening);
    tick(1'b1); chk_st("tog2", 20, c_opening);
    tick(1'b0); chk_st("tog3", 10, c_closing);
    tick(1'b1); chk_st("tog4", 20, c_opening);

    // h=20: box rows 220..259
    pix("h20_edge_top", 320, 223, 7);
    pix("h20_fill_top", 320, 224, 3);
    pix("h20_out_top",  320, 219, 0);
    pix("h20_edge_bot", 320, 259, 7);
    pix("h20_out_bot",  320, 260, 0);

    // Reset mid-opening at h=40
    tick(1'b1);
    tick(1'b1);
    chk_st("pre_rst", 40, c_opening);
    x = 10'd320;
    y = 10'd240;
    @(posedge clk);
    #2;
    chk("pre_rst_rgb", 32'(rgb), 3);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_rgb", 32'(rgb), 0);
    chk("mid_rst_vis", 32'(visible), 0);
    chk_st("mid_rst", 0, c_closed);
    x = '0;
    y = '0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick(1'b1);
    chk_st("restart", 10, c_opening);

`ifdef MSG_BLINK_EN
    repeat (9) tick(1'b1);
    chk_st("blink_open", 100, c_open);
    for (int k = 0; k < 35; k++) begin
      pix($sformatf("blink%0d", k), 202, 240, ((k % 30) < 15) ? 7 : 3);
      tick(1'b1);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", r_checks, r_errors);
    $finish;
  end

endmodule
`default_nettype wire
